// File: rtl/div_seq.sv
// Operand sequencer in front of the fixed-point divider: takes (a, b), drives the
// divider for DIV_LAT cycles, then returns the quotient (or a saturated result on b == 0).
module div_seq #(
  parameter int A_W     = 12,
  parameter int FRAC    = 14,
  parameter int N       = 14,
  parameter int DIV_LAT = 27,
  localparam int M      = A_W + FRAC
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [A_W-1:0] in_a,
  input  logic [N-1:0] in_b,
  output logic [M-1:0] dividend,
  output logic [N-1:0] divisor,
  output logic         en,
  input  logic [M-1:0] quotient,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [M-1:0] out_q,
  output logic         out_dz
);

  localparam int CNT_W = $clog2(DIV_LAT + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV_LAT - 1);

  typedef enum logic [1:0] {IDLE, RUN, OUT} state_e;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [M-1:0]     dividend_q;
  logic [N-1:0]     divisor_q;
  logic             en_q;
  logic [M-1:0]     res_q;
  logic             dz_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      dividend_q <= '0;
      divisor_q  <= '0;
      en_q       <= 1'b0;
      res_q      <= '0;
      dz_q       <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            dividend_q <= M'(in_a) << FRAC;
            divisor_q  <= in_b;
            if (in_b != '0) begin
              en_q    <= 1'b1;
              cnt_q   <= '0;
              state_q <= RUN;
            end else begin
              // Zero divisor never reaches the divider; saturate and flag instead.
              res_q   <= '1;
              dz_q    <= 1'b1;
              state_q <= OUT;
            end
          end
        end
        RUN: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            res_q   <= quotient;
            dz_q    <= 1'b0;
            en_q    <= 1'b0;
            state_q <= OUT;
          end
        end
        OUT: begin
          if (out_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == OUT);
  assign dividend  = dividend_q;
  assign divisor   = divisor_q;
  assign en        = en_q;
  assign out_q     = res_q;
  assign out_dz    = dz_q;

endmodule

// File: tb/tb_div_seq.sv
// Bench for div_seq: transaction-level model plus a divider stub, compared every cycle,
// with directed operations pinned to hand-computed values followed by random traffic.
module tb_div_seq;
  localparam int A_W     = 12;
  localparam int FRAC    = 14;
  localparam int N       = 14;
  localparam int DIV_LAT = 27;
  localparam int M       = A_W + FRAC;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [A_W-1:0] in_a;
  logic [N-1:0]   in_b;
  logic [M-1:0]   dividend;
  logic [N-1:0]   divisor;
  logic           en;
  logic [M-1:0]   quotient = '0;
  logic           out_valid;
  logic           out_ready;
  logic [M-1:0]   out_q;
  logic           out_dz;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  bit cmp_on = 1'b0;

  div_seq #(.A_W(A_W), .FRAC(FRAC), .N(N), .DIV_LAT(DIV_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .dividend(dividend), .divisor(divisor), .en(en),
    .quotient(quotient), .out_valid(out_valid), .out_ready(out_ready),
    .out_q(out_q), .out_dz(out_dz)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  // Divider stub: garbage until en has been high DIV_LAT cycles, then the true quotient.
  int qcnt = 0;
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) qcnt = 0;
    else begin
      if (en) qcnt = qcnt + 1;
      else    qcnt = 0;
      if (qcnt >= DIV_LAT && divisor != '0) quotient = dividend / M'(divisor);
      else                                  quotient = M'($urandom);
    end
  end

  // Transaction model: an op is busy from acceptance until its result is taken.
  bit           m_busy = 0, m_outv = 0, m_en = 0, m_odz = 0;
  logic [M-1:0] m_div = '0, m_oq = '0, m_res = '0;
  logic [N-1:0] m_dvs = '0;
  int           m_rem = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 0; m_outv = 0; m_en = 0; m_odz = 0;
      m_div = '0; m_dvs = '0; m_oq = '0; m_rem = 0;
    end else if (m_outv) begin
      if (out_ready) begin m_busy = 0; m_outv = 0; end
    end else if (m_busy) begin
      m_rem = m_rem - 1;
      if (m_rem == 0) begin m_en = 0; m_outv = 1; m_oq = m_res; m_odz = 0; end
    end else if (in_valid) begin
      m_div  = M'(in_a) * (M'(1) << FRAC);
      m_dvs  = in_b;
      m_busy = 1;
      if (in_b == '0) begin
        m_outv = 1; m_oq = '1; m_odz = 1;
      end else begin
        m_en = 1; m_rem = DIV_LAT; m_res = m_div / M'(in_b);
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_on) begin
      chk("in_ready",  32'(in_ready),  32'(!m_busy));
      chk("out_valid", 32'(out_valid), 32'(m_outv));
      chk("en",        32'(en),        32'(m_en));
      chk("dividend",  32'(dividend),  32'(m_div));
      chk("divisor",   32'(divisor),   32'(m_dvs));
      chk("out_q",     32'(out_q),     32'(m_oq));
      chk("out_dz",    32'(out_dz),    32'(m_odz));
    end
  end

  // Run lengths of en high / low, for the pinned pulse-width and gap checks.
  int en_run = 0, en_last = 0, low_run = 0, low_last = 0;
  always @(negedge clk) begin
    if (en) begin
      if (low_run != 0) low_last = low_run;
      low_run = 0;
      en_run  = en_run + 1;
    end else begin
      if (en_run != 0) en_last = en_run;
      en_run  = 0;
      low_run = low_run + 1;
    end
  end

  task automatic drive(input logic [A_W-1:0] a, input logic [N-1:0] b);
    in_a = a; in_b = b; in_valid = 1'b1;
  endtask

  task automatic wait_acc(output int acc);
    bit r;
    int n;
    n = 0; acc = -1;
    do begin
      @(negedge clk); r = in_ready;
      @(posedge clk); #1; n++;
    end while (!r && n < 200);
    if (!r) begin
      checks++; errors++;
      $display("FAIL acc_timeout: no acceptance after %0d cycles", n);
    end else acc = cyc;
  endtask

  task automatic wait_out(input int acc, output int lat);
    int n;
    n = 0; lat = -1;
    do begin @(negedge clk); n++; end while (!out_valid && n < 200);
    if (!out_valid) begin
      checks++; errors++;
      $display("FAIL out_timeout: out_valid not seen after %0d cycles", n);
    end else lat = cyc - acc;
  endtask

  int acc, acc2, lat;

  initial begin
    rst_n = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_en",        32'(en),        32'd0);
    chk("rst_dividend",  32'(dividend),  32'd0);
    chk("rst_out_q",     32'(out_q),     32'd0);
    cmp_on = 1'b1;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;

    // Nominal divide.
    drive(12'h9D6, 14'h0B4B); wait_acc(acc); in_valid = 1'b0;
    chk("op1_dividend", 32'(dividend), 32'h2758000);
    wait_out(acc, lat);
    chk("op1_q",   32'(out_q),  32'h00037BE);
    chk("op1_dz",  32'(out_dz), 32'd0);
    chk("op1_lat", lat,         32'd27);
    @(posedge clk); #1;
    chk("op1_en_width", en_last, 32'd27);

    // Divide by zero.
    drive(12'h123, 14'h0); wait_acc(acc); in_valid = 1'b0;
    chk("dz_valid_next_cycle", 32'(out_valid), 32'd1);
    chk("dz_en", 32'(en),     32'd0);
    chk("dz_q",  32'(out_q),  32'h3FFFFFF);
    chk("dz_flag", 32'(out_dz), 32'd1);
    @(posedge clk); #1;

    // Backpressure hold.
    out_ready = 1'b0;
    drive(12'hFFF, 14'h1); wait_acc(acc); in_valid = 1'b0;
    wait_out(acc, lat);
    for (int i = 0; i < 5; i++) begin
      chk("hold_q",     32'(out_q),     32'h3FFC000);
      chk("hold_ready", 32'(in_ready),  32'd0);
      chk("hold_valid", 32'(out_valid), 32'd1);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("hold_drop_valid", 32'(out_valid), 32'd0);
    chk("hold_drop_ready", 32'(in_ready),  32'd1);

    // Back-to-back with in_valid held high.
    drive(12'h001, 14'h3FFF); wait_acc(acc);
    drive(12'h800, 14'h2000);
    wait_out(acc, lat);
    chk("b2b_q1", 32'(out_q), 32'h0000001);
    wait_acc(acc2); in_valid = 1'b0;
    chk("b2b_period", acc2 - acc, 32'd29);
    wait_out(acc2, lat);
    chk("b2b_q2",     32'(out_q), 32'h0001000);
    chk("b2b_en_gap", low_last,   32'd2);
    @(posedge clk); #1;

    // Asynchronous reset in the middle of RUN.
    drive(12'h9D6, 14'h0B4B); wait_acc(acc); in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_en",    32'(en),        32'd0);
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_q",     32'(out_q),     32'd0);
    chk("arst_ready", 32'(in_ready),  32'd1);
    @(posedge clk); #2 rst_n = 1'b1;
    @(posedge clk); #1;
    drive(12'h9D6, 14'h0B4B); wait_acc(acc); in_valid = 1'b0;
    wait_out(acc, lat);
    chk("post_rst_q",   32'(out_q), 32'h00037BE);
    chk("post_rst_lat", lat,        32'd27);
    @(posedge clk); #1;

    // Inputs changing while the divider runs.
    drive(12'h9D6, 14'h0B4B); wait_acc(acc);
    in_valid = 1'b0; in_a = 12'hABC; in_b = 14'h0003;
    repeat (5) @(posedge clk); #1;
    chk("run_dividend", 32'(dividend), 32'h2758000);
    chk("run_divisor",  32'(divisor),  32'h0B4B);
    wait_out(acc, lat);
    chk("run_q", 32'(out_q), 32'h00037BE);
    @(posedge clk); #1;

    // Random traffic, including zero / extreme operands and random backpressure.
    for (int i = 0; i < 3000; i++) begin
      in_valid = 1'($urandom);
      in_a = ($urandom_range(0, 7) == 0) ? '1 : A_W'($urandom);
      case ($urandom_range(0, 7))
        0:       in_b = '0;
        1:       in_b = 14'h1;
        2:       in_b = '1;
        default: in_b = N'($urandom);
      endcase
      out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (60) @(posedge clk);
    @(negedge clk);
    cmp_on = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/div_seq.md
# div_seq

Operand sequencer placed directly upstream of the fixed-point `divider`. It accepts an (a, b) pair over a valid/ready handshake and forms the scaled dividend `{a, FRAC zeros}` and the divisor. It pulses the divider's `en` for exactly the divider latency, then captures `quotient` and presents it downstream with a valid/ready handshake. A zero divisor bypasses the divider and returns a saturated result with a flag.

## Interface
- `A_W`, default 12: width of operand a.
- `FRAC`, default 14: fractional bits appended to a; `M = A_W + FRAC` (26) is the dividend/quotient width.
- `N`, default 14: divisor width.
- `DIV_LAT`, default 27: cycles `en` must be held high before `quotient` is valid. Must be ≥ 1.

- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: operand pair offered.
- `in_ready` out 1: block can accept an operand pair.
- `in_a` in A_W: numerator integer.
- `in_b` in N: divisor.
- `dividend` out M: to divider, `{in_a, FRAC'b0}`, registered.
- `divisor` out N: to divider, registered.
- `en` out 1: divider enable, registered.
- `quotient` in M: from divider.
- `out_valid` out 1: result available.
- `out_ready` in 1: downstream accepts result.
- `out_q` out M: result.
- `out_dz` out 1: divide-by-zero flag, qualified by `out_valid`.

## Operation
- FSM states IDLE, RUN, OUT.
- IDLE:
  - `in_ready`=1.
  - On `in_valid`&`in_ready` (acceptance), load `dividend`/`divisor`.
  - If `in_b`≠0: `en`←1, counter←0, go to RUN.
  - If `in_b`=0: `out_q`←all ones, `out_dz`←1, go to OUT; `en` stays 0.
- RUN:
  - `in_ready`=0, counter increments each edge.
  - At the edge where counter = DIV_LAT−1: `out_q`←`quotient`, `out_dz`←0, `en`←0, go to OUT.
- OUT:
  - `out_valid`=1, `in_ready`=0.
  - On `out_ready`, go to IDLE.
  - `out_q`/`out_dz` hold while `out_ready` is low.
- `in_ready` = (state==IDLE); `out_valid` = (state==OUT). Both are decoded from registered state only, with no combinational path from inputs.
- `dividend`/`divisor` stay stable from acceptance until the next acceptance. `out_q`/`out_dz` stay stable until overwritten by the next result.
- Counter width is ceil(log2(DIV_LAT+1)). It never wraps in RUN.
- Inputs `in_a`/`in_b` are sampled only at acceptance. Later changes are ignored.

## Timing
- Acceptance at edge k (b≠0): `en`=1 from k until edge k+DIV_LAT, so it is high for exactly DIV_LAT cycles.
  - `quotient` is sampled at edge k+DIV_LAT.
  - `out_valid`=1 from edge k+DIV_LAT.
- Acceptance at edge k (b=0): `out_valid`=1 from edge k+1 (latency 1); `en` never rises.
- `out_valid`&`out_ready` at edge j: `out_valid`=0 and `in_ready`=1 after edge j. The earliest next acceptance is edge j+1.
  - `en` is therefore low for ≥2 cycles between operations.
  - Minimum period is DIV_LAT+2 cycles.
- Reset values (immediate on `rst_n` low, independent of `clk`): state IDLE, `en`=0, `dividend`=0, `divisor`=0, `out_q`=0, `out_dz`=0, `out_valid`=0, `in_ready`=1, counter=0.
- Reset during RUN or OUT: the operation and any pending result are discarded, and `en` drops asynchronously. After `rst_n` rises, the first acceptance follows normal timing.
- No acceptance can occur while `rst_n` is low.

## Test plan
Bench divider model: drives `quotient`=X until `en` has been high DIV_LAT cycles, then floor(dividend/divisor).

- a=0x9D6, b=0x0B4B, `out_ready`=1 → `dividend`=0x2758000, `en` high exactly 27 cycles, `out_q`=0x00037BE, `out_dz`=0, `out_valid` 27 cycles after acceptance.
- a=0x123, b=0 → `en` never rises, `out_q`=0x3FFFFFF, `out_dz`=1, `out_valid` one cycle after acceptance.
- a=0xFFF, b=1 with `out_ready` low 5 cycles → `out_q`=0x3FFC000 held stable for 5 cycles with `in_ready`=0; drops after the handshake.
- Back-to-back: a=1, b=0x3FFF then a=0x800, b=0x2000 with `in_valid` held high → results 0x0000001 then 0x0001000; `en` low ≥2 cycles between the ops; period 29 cycles.
- `rst_n` low at counter=10 in RUN → `en`, `out_valid`, `out_q` go 0 asynchronously and `in_ready`=1. A new op (a=0x9D6, b=0x0B4B) then completes with 0x00037BE.
- Change `in_a`/`in_b` during RUN → `dividend`/`divisor` and the result are unaffected.
